aqp_cpu_bus_bridge: RTL and testbench

//  Consumes the Z80-style strobes produced by the T80 CPU wrapper and converts each memory/IO access into one
//  req/ack transaction on the internal fabric; holds wait_n low until the fabric acknowledges.

---
 rtl/aqp_cpu_bus_bridge_if.sv | 33 +++
 rtl/aqp_cpu_bus_bridge.sv | 132 +++++++++++++
 tb/tb_aqp_cpu_bus_bridge.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/aqp_cpu_bus_bridge_if.sv
// Signal bundle between the Z80-style CPU strobes, the bridge and the req/ack fabric.
// The bridge connects through the slave modport, and the CPU/fabric side connects through the master modport.
interface aqp_cpu_bus_bridge_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dq_out;
  logic        cpu_mreq_n;
  logic        cpu_iorq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic        cpu_busak_n;
  logic        cpu_wait_n;
  logic [7:0]  cpu_dq_in;
  logic        bus_req;
  logic        bus_ack;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wrdata;
  logic        bus_wr;
  logic        bus_io;
  logic [7:0]  bus_rddata;
  logic        bus_err;

  modport slave (
    input  cpu_addr, cpu_dq_out, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_busak_n,
    input  bus_ack, bus_rddata,
    output cpu_wait_n, cpu_dq_in, bus_req, bus_addr, bus_wrdata, bus_wr, bus_io, bus_err
  );

  modport master (
    output cpu_addr, cpu_dq_out, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_busak_n,
    output bus_ack, bus_rddata,
    input  cpu_wait_n, cpu_dq_in, bus_req, bus_addr, bus_wrdata, bus_wr, bus_io, bus_err
  );
endinterface

// File: rtl/aqp_cpu_bus_bridge.sv
// Turns each Z80 memory/IO strobe cycle into one req/ack fabric transaction, stalling the CPU via wait_n.
// Defining AQP_BUS_TIMEOUT_EN adds a force-complete timeout with a sticky bus_err flag.
module aqp_cpu_bus_bridge #(
`ifdef AQP_BUS_TIMEOUT_EN
  parameter int         TIMEOUT_CYCLES = 1023,
`endif
  parameter logic [7:0] INTACK_DATA    = 8'hFF
) (
  input  logic                clk,
  input  logic                reset_n,
  aqp_cpu_bus_bridge_if.slave bif
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  state_e      state_q, state_d;
  logic        access_q, intack_q;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  dq_q, dq_d;
  logic        wr_q, wr_d;
  logic        io_q, io_d;
  logic        strobe, access, start, intack;
`ifdef AQP_BUS_TIMEOUT_EN
  logic [9:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
`endif

  // strobe ignores busak_n so that releasing the bus cannot abort a cycle already in flight
  assign strobe = (~bif.cpu_rd_n | ~bif.cpu_wr_n) & (~bif.cpu_mreq_n | ~bif.cpu_iorq_n);
  assign access = bif.cpu_busak_n & strobe;
  assign start  = access & ~access_q;
  assign intack = ~bif.cpu_iorq_n & bif.cpu_mreq_n & bif.cpu_rd_n & bif.cpu_wr_n;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dq_d    = dq_q;
    wr_d    = wr_q;
    io_d    = io_q;
`ifdef AQP_BUS_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    if (intack && !intack_q) dq_d = INTACK_DATA;
    unique case (state_q)
      IDLE: if (start) begin
        addr_d  = bif.cpu_addr;
        wdata_d = bif.cpu_dq_out;
        wr_d    = ~bif.cpu_wr_n;
        io_d    = ~bif.cpu_iorq_n;
        req_d   = 1'b1;
        state_d = REQ;
`ifdef AQP_BUS_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      REQ: begin
        if (bif.bus_ack) begin
          req_d = 1'b0;
          // CPU already gone: complete on the fabric but drop the data
          if (strobe) begin
            if (!wr_q) dq_d = bif.bus_rddata;
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef AQP_BUS_TIMEOUT_EN
        else if (tmo_q == 10'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          if (!wr_q) dq_d = 8'hFF;
          err_d   = 1'b1;
          state_d = HOLD;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
`endif
      end
      HOLD: if (!strobe) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      access_q <= 1'b0;
      intack_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      dq_q     <= 8'hFF;
      wr_q     <= 1'b0;
      io_q     <= 1'b0;
`ifdef AQP_BUS_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      access_q <= access;
      intack_q <= intack;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dq_q     <= dq_d;
      wr_q     <= wr_d;
      io_q     <= io_d;
`ifdef AQP_BUS_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  // wait drops combinationally in the strobe's first clk; start is masked while reset is held
  assign bif.cpu_wait_n = ~((start & reset_n) | (state_q == REQ));
  assign bif.cpu_dq_in  = dq_q;
  assign bif.bus_req    = req_q;
  assign bif.bus_addr   = addr_q;
  assign bif.bus_wrdata = wdata_q;
  assign bif.bus_wr     = wr_q;
  assign bif.bus_io     = io_q;
`ifdef AQP_BUS_TIMEOUT_EN
  assign bif.bus_err    = err_q;
`else
  assign bif.bus_err    = 1'b0;
`endif
endmodule

// File: tb/tb_aqp_cpu_bus_bridge.sv
// Randomized bench for aqp_cpu_bus_bridge: scenario-level expectations checked every clk plus literal anchors.
module tb_aqp_cpu_bus_bridge;
  localparam logic [7:0] INTACK = 8'hFF;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  aqp_cpu_bus_bridge_if bif();
  aqp_cpu_bus_bridge dut (.clk(clk), .reset_n(reset_n), .bif(bif.slave));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  logic        exp_wait, exp_req, exp_wr, exp_io, exp_err;
  logic [15:0] exp_addr;
  logic [7:0]  exp_wd, exp_dq;

  int   wait_lo = 0, req_rise = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the scenario expectations
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cpu_wait_n", 16'(bif.cpu_wait_n), 16'(exp_wait));
      chk("bus_req",    16'(bif.bus_req),    16'(exp_req));
      chk("bus_addr",   bif.bus_addr,        exp_addr);
      chk("bus_wrdata", 16'(bif.bus_wrdata), 16'(exp_wd));
      chk("bus_wr",     16'(bif.bus_wr),     16'(exp_wr));
      chk("bus_io",     16'(bif.bus_io),     16'(exp_io));
      chk("cpu_dq_in",  16'(bif.cpu_dq_in),  16'(exp_dq));
      chk("bus_err",    16'(bif.bus_err),    16'(exp_err));
    end
    if (!bif.cpu_wait_n) wait_lo <= wait_lo + 1;
    if (bif.bus_req && !req_prev) req_rise <= req_rise + 1;
    req_prev <= bif.bus_req;
  end

  task automatic exp_reset();
    exp_wait = 1'b1; exp_req = 1'b0; exp_wr = 1'b0; exp_io = 1'b0;
    exp_addr = '0; exp_wd = '0; exp_dq = 8'hFF; exp_err = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_strobes();
    bif.cpu_mreq_n = 1'b1; bif.cpu_iorq_n = 1'b1; bif.cpu_rd_n = 1'b1; bif.cpu_wr_n = 1'b1;
  endtask

  task automatic set_strobes(input bit io, input bit wr);
    idle_strobes();
    if (io) bif.cpu_iorq_n = 1'b0; else bif.cpu_mreq_n = 1'b0;
    if (wr) bif.cpu_wr_n = 1'b0; else bif.cpu_rd_n = 1'b0;
  endtask

  // One CPU access: ack arrives d clks after the first REQ clk; strobes held h extra clks,
  // or dropped in the first REQ clk when drop is set (data then discarded).
  task automatic xact(input bit io, input bit wr, input logic [15:0] a, input logic [7:0] wd,
                      input logic [7:0] rdv, input int d, input int h, input bit drop);
    cyc();
    bif.bus_ack = 1'b0; bif.cpu_addr = a; bif.cpu_dq_out = wd; set_strobes(io, wr);
    exp_wait = 1'b0;
    for (int c = 1; c <= d + 1; c++) begin
      cyc();
      if (c == 1) begin
        exp_req = 1'b1; exp_addr = a; exp_wd = wd; exp_wr = wr; exp_io = io;
        bif.cpu_addr = 16'($urandom); bif.cpu_dq_out = 8'($urandom);
        if (drop) idle_strobes();
      end
      bif.bus_ack    = (c == d + 1);
      bif.bus_rddata = (c == d + 1) ? rdv : 8'($urandom);
    end
    cyc();
    bif.bus_ack = 1'b0; bif.bus_rddata = 8'($urandom);
    exp_req = 1'b0; exp_wait = 1'b1;
    if (!drop && !wr) exp_dq = rdv;
    if (!drop) begin
      repeat (h) cyc();
      cyc();
      idle_strobes();
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      cyc();
      bif.bus_ack = ($urandom_range(0, 3) == 0);
      bif.bus_rddata = 8'($urandom);
    end
  endtask

  task automatic refresh();
    cyc(); bif.bus_ack = 1'b0; bif.cpu_mreq_n = 1'b0;
    cyc();
    cyc(); idle_strobes();
  endtask

  task automatic intack();
    cyc(); bif.bus_ack = 1'b0; bif.cpu_iorq_n = 1'b0;
    cyc(); exp_dq = INTACK;
    cyc(); idle_strobes();
  endtask

  task automatic busak_access(input bit io, input bit wr);
    cyc(); bif.bus_ack = 1'b0; bif.cpu_busak_n = 1'b0; set_strobes(io, wr);
    cyc();
    cyc(); idle_strobes(); bif.cpu_busak_n = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int w0, r0;

  initial begin
    idle_strobes();
    bif.cpu_busak_n = 1'b1; bif.bus_ack = 1'b0; bif.bus_rddata = '0;
    bif.cpu_addr = '0; bif.cpu_dq_out = '0;
    exp_reset();
    #1 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) cyc();
    reset_n = 1'b1;
    gap(2);

    // Memory read, ack three clks after start
    w0 = wait_lo; r0 = req_rise;
    xact(1'b0, 1'b0, 16'h1234, 8'h00, 8'h5A, 2, 1, 1'b0);
    settle();
    chk("rd_wait_low_cycles", 16'(wait_lo - w0), 16'd4);
    chk("rd_req_count", 16'(req_rise - r0), 16'd1);
    chk("rd_dq_in", 16'(bif.cpu_dq_in), 16'h005A);
    chk("rd_bus_io", 16'(bif.bus_io), 16'd0);

    // IO write, ack in first REQ clk
    w0 = wait_lo; r0 = req_rise;
    xact(1'b1, 1'b1, 16'h00F6, 8'hC3, 8'h00, 0, 0, 1'b0);
    settle();
    chk("wr_wait_low_cycles", 16'(wait_lo - w0), 16'd2);
    chk("wr_req_count", 16'(req_rise - r0), 16'd1);
    chk("wr_bus_wr", 16'(bif.bus_wr), 16'd1);
    chk("wr_bus_io", 16'(bif.bus_io), 16'd1);
    chk("wr_wrdata", 16'(bif.bus_wrdata), 16'h00C3);
    chk("wr_addr", bif.bus_addr, 16'h00F6);

    // Refresh then interrupt acknowledge
    gap(1);
    w0 = wait_lo; r0 = req_rise;
    refresh();
    intack();
    settle();
    chk("ri_wait_low_cycles", 16'(wait_lo - w0), 16'd0);
    chk("ri_req_count", 16'(req_rise - r0), 16'd0);
    chk("ri_dq_in", 16'(bif.cpu_dq_in), 16'h00FF);

    // Spurious ack in IDLE, then a read held 10 clks with ack at clk 2
    cyc(); bif.bus_ack = 1'b1;
    w0 = wait_lo; r0 = req_rise;
    xact(1'b0, 1'b0, 16'h4321, 8'h77, 8'h3C, 1, 7, 1'b0);
    settle();
    chk("sp_req_count", 16'(req_rise - r0), 16'd1);
    chk("sp_wait_low_cycles", 16'(wait_lo - w0), 16'd3);
    chk("sp_dq_in", 16'(bif.cpu_dq_in), 16'h003C);

    // Reset pulsed in the middle of REQ
    gap(1);
    cyc(); bif.bus_ack = 1'b0; bif.cpu_addr = 16'hBEEF; bif.cpu_dq_out = 8'h11; set_strobes(1'b0, 1'b1);
    exp_wait = 1'b0;
    cyc(); exp_req = 1'b1; exp_addr = 16'hBEEF; exp_wd = 8'h11; exp_wr = 1'b1; exp_io = 1'b0;
    cyc();
    reset_n = 1'b0;
    exp_reset();
    #1;
    chk("mid_rst_bus_req", 16'(bif.bus_req), 16'd0);
    chk("mid_rst_wait_n", 16'(bif.cpu_wait_n), 16'd1);
    cyc(); idle_strobes(); reset_n = 1'b1;
    gap(1);
    r0 = req_rise;
    xact(1'b1, 1'b0, 16'h0055, 8'h00, 8'hA5, 1, 0, 1'b0);
    settle();
    chk("post_rst_req_count", 16'(req_rise - r0), 16'd1);
    chk("post_rst_dq_in", 16'(bif.cpu_dq_in), 16'h00A5);

    // Randomized mix of accesses and special cycles
    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k <= 5)
        xact(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 4), $urandom_range(0, 2), 1'b0);
      else if (k == 6)
        xact(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
             $urandom_range(0, 4), 0, 1'b1);
      else if (k == 7) refresh();
      else if (k == 8) intack();
      else busak_access(1'($urandom), 1'($urandom));
      gap($urandom_range(0, 2));
    end

`ifdef AQP_BUS_TIMEOUT_EN
    // Stalled read with no ack is force-completed
    cyc(); bif.bus_ack = 1'b0; bif.cpu_addr = 16'h2000; bif.cpu_dq_out = 8'h00; set_strobes(1'b0, 1'b0);
    exp_wait = 1'b0;
    cyc(); exp_req = 1'b1; exp_addr = 16'h2000; exp_wd = 8'h00; exp_wr = 1'b0; exp_io = 1'b0;
    repeat (1022) cyc();
    cyc(); exp_req = 1'b0; exp_wait = 1'b1; exp_dq = 8'hFF; exp_err = 1'b1;
    cyc(); idle_strobes();
    gap(3);
    settle();
    chk("tmo_bus_err", 16'(bif.bus_err), 16'd1);
`endif

    gap(2);
    settle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
